// File: rtl/nic8_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// nic8_instr_encoder_if
//   Bus bundle between an instruction requester (boot loader / bench) and the
//   nic8 instruction encoder, including the program-memory write port.
//
//   Request side : org_valid/org_addr (set write origin), in_valid/in_ready
//                  handshake with the symbolic fields in_cond, in_src,
//                  in_indexed, in_dest, in_imm.
//   Memory side  : wr_en/wr_addr/wr_data write strobe, mem_ready acceptance.
//   Status       : err (rejected request pulse), wrapped (sticky address
//                  rollover), instr_count (saturating instruction count).
//
//   Modports:
//     master - the requester; it also plays the memory and drives mem_ready.
//     slave  - the encoder.
// ---------------------------------------------------------------------------
interface nic8_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              org_valid;
  logic [ADDR_W-1:0] org_addr;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_cond;
  logic [1:0]        in_src;
  logic              in_indexed;
  logic [2:0]        in_dest;
  logic [7:0]        in_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              mem_ready;
  logic              err;
  logic              wrapped;
  logic [15:0]       instr_count;

  modport master (
    output org_valid, org_addr, in_valid, in_cond, in_src, in_indexed,
           in_dest, in_imm, mem_ready,
    input  in_ready, wr_en, wr_addr, wr_data, err, wrapped, instr_count
  );

  modport slave (
    input  org_valid, org_addr, in_valid, in_cond, in_src, in_indexed,
           in_dest, in_imm, mem_ready,
    output in_ready, wr_en, wr_addr, wr_data, err, wrapped, instr_count
  );
endinterface

// File: rtl/nic8_instr_encoder.sv
// ---------------------------------------------------------------------------
// nic8_instr_encoder
//   Turns symbolic nic8 instruction requests into the encoded byte stream and
//   writes it to program memory at an auto-incrementing address.
//
//   Encoding: ir = {cond[1:0], src[1:0], indexed, dest[2:0]}. An immediate
//   source (src=0, indexed=0) is followed by one operand byte. A memory-to-
//   memory request (src=0, indexed=1, dest=5) is accepted but rejected with
//   a one-cycle err pulse and produces no write.
//
//   Ports:
//     clk       system clock, all state changes on the rising edge
//     resetBar  synchronous active-low reset
//     bus       nic8_instr_encoder_if.slave (request, memory write, status)
//
//   Parameters:
//     ADDR_W    program memory address width
//     BASE      write address after reset
// ---------------------------------------------------------------------------
module nic8_instr_encoder #(
  parameter int                ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic                  clk,
  input  logic                  resetBar,
  nic8_instr_encoder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_IMM  = 2'd2
  } state_e;

  localparam logic [1:0] SRC_MEM    = 2'd0;
  localparam logic [2:0] DEST_STORE = 3'd5;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              wr_en_q,    wr_en_d;
  logic [7:0]        wr_data_q,  wr_data_d;
  logic [7:0]        imm_q,      imm_d;
  logic              need_imm_q, need_imm_d;
  logic              err_q,      err_d;
  logic              wrapped_q,  wrapped_d;
  logic [15:0]       count_q,    count_d;

  logic in_ready;
  logic accept;
  logic illegal;
  logic byte_done;
  logic instr_done;

  // in_ready is a direct function of org_valid in IDLE, so it cannot be a
  // flop; it is forced low while reset is being applied.
  assign in_ready = resetBar && (state_q == ST_IDLE) && !bus.org_valid;
  assign accept   = bus.in_valid && in_ready;
  assign illegal  = (bus.in_src == SRC_MEM) && bus.in_indexed &&
                    (bus.in_dest == DEST_STORE);

  // A byte leaves the encoder whenever a write strobe meets mem_ready.
  assign byte_done = (state_q != ST_IDLE) && bus.mem_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    wr_en_d    = wr_en_q;
    wr_data_d  = wr_data_q;
    imm_d      = imm_q;
    need_imm_d = need_imm_q;
    err_d      = 1'b0;
    wrapped_d  = wrapped_q;
    count_d    = count_q;
    instr_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.org_valid) begin
          addr_d = bus.org_addr;
        end else if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            wr_data_d  = {bus.in_cond, bus.in_src, bus.in_indexed, bus.in_dest};
            imm_d      = bus.in_imm;
            need_imm_d = (bus.in_src == SRC_MEM) && !bus.in_indexed;
            state_d    = ST_OP;
          end
        end
      end

      ST_OP: begin
        if (bus.mem_ready) begin
          if (need_imm_q) begin
            wr_data_d = imm_q;
            state_d   = ST_IMM;
          end else begin
            wr_en_d    = 1'b0;
            state_d    = ST_IDLE;
            instr_done = 1'b1;
          end
        end
      end

      ST_IMM: begin
        if (bus.mem_ready) begin
          wr_en_d    = 1'b0;
          state_d    = ST_IDLE;
          instr_done = 1'b1;
        end
      end

      default: begin
        wr_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Address advance is shared by both write states; rolling over from
    // all-ones marks the sticky wrap flag.
    if (byte_done) begin
      addr_d = addr_q + 1'b1;
      if (&addr_q) begin
        wrapped_d = 1'b1;
      end
    end

    if (instr_done && (count_q != COUNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      state_q    <= ST_IDLE;
      addr_q     <= BASE;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      imm_q      <= 8'h00;
      need_imm_q <= 1'b0;
      err_q      <= 1'b0;
      wrapped_q  <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      imm_q      <= imm_d;
      need_imm_q <= need_imm_d;
      err_q      <= err_d;
      wrapped_q  <= wrapped_d;
      count_q    <= count_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.err         = err_q;
  assign bus.wrapped     = wrapped_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_nic8_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_nic8_instr_encoder
//   Self-checking bench for nic8_instr_encoder. A transaction-level model
//   turns every accepted request into the list of bytes it must produce and
//   a monitor compares the DUT against it on every falling edge. Directed
//   sequences with literal expectations pin the model, then a randomized
//   phase exercises org loads, stalls, illegal requests and resets.
// ---------------------------------------------------------------------------
module tb_nic8_instr_encoder;

  localparam int          ADDR_W = 8;
  localparam logic [7:0]  BASE   = 8'h00;

  logic clk = 1'b0;
  logic resetBar;

  always #5 clk = ~clk;

  nic8_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  nic8_instr_encoder #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         last;   // final byte of its instruction
  } wr_t;

  wr_t        exp_q[$];   // bytes still to be written, in order
  logic [7:0] m_addr;     // next free address when no write is pending
  int         m_count;
  bit         m_wrapped;
  bit         m_err;
  bit         mon_en = 1'b0;

  // Check the current outputs, then advance the model by the coming edge.
  // Inputs only change just after a rising edge, so what is seen here is
  // exactly what the DUT will sample.
  always @(negedge clk) begin : monitor
    wr_t w;
    int  op;
    bit  two;
    if (mon_en) begin
      check("in_ready", bus.in_ready,
            resetBar && (exp_q.size() == 0) && !bus.org_valid);
      check("wr_en", bus.wr_en, exp_q.size() != 0);
      check("wr_addr", bus.wr_addr, (exp_q.size() != 0) ? exp_q[0].addr : m_addr);
      if (exp_q.size() != 0) check("wr_data", bus.wr_data, exp_q[0].data);
      check("err", bus.err, m_err);
      check("wrapped", bus.wrapped, m_wrapped);
      check("instr_count", bus.instr_count, m_count);
    end

    if (!resetBar) begin
      exp_q.delete();
      m_addr    = BASE;
      m_count   = 0;
      m_wrapped = 1'b0;
      m_err     = 1'b0;
    end else begin
      m_err = 1'b0;
      if (exp_q.size() != 0) begin
        if (bus.mem_ready) begin
          w = exp_q.pop_front();
          if (w.addr == 8'hFF) m_wrapped = 1'b1;
          if (w.last && m_count < 65535) m_count++;
        end
      end else if (bus.org_valid) begin
        m_addr = bus.org_addr;
      end else if (bus.in_valid) begin
        if (bus.in_src == 2'd0 && bus.in_indexed && bus.in_dest == 3'd5) begin
          m_err = 1'b1;
        end else begin
          op  = bus.in_cond * 64 + bus.in_src * 16 + bus.in_indexed * 8 + bus.in_dest;
          two = (bus.in_src == 2'd0) && !bus.in_indexed;
          exp_q.push_back('{m_addr, 8'(op), !two});
          if (two) exp_q.push_back('{m_addr + 8'd1, bus.in_imm, 1'b1});
          m_addr = m_addr + (two ? 8'd2 : 8'd1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_defaults;
    bus.org_valid  = 1'b0;
    bus.org_addr   = 8'h00;
    bus.in_valid   = 1'b0;
    bus.in_cond    = 2'd0;
    bus.in_src     = 2'd0;
    bus.in_indexed = 1'b0;
    bus.in_dest    = 3'd0;
    bus.in_imm     = 8'h00;
    bus.mem_ready  = 1'b1;
  endtask

  task automatic do_reset;
    resetBar = 1'b0;
    step();
    resetBar = 1'b1;
  endtask

  // Present a request until it is accepted; returns just after the accept
  // edge with the fields scrambled so late changes are exercised.
  task automatic send(input logic [1:0] c, input logic [1:0] s, input logic i,
                      input logic [2:0] d, input logic [7:0] imm);
    bit acc = 1'b0;
    bus.in_cond    = c;
    bus.in_src     = s;
    bus.in_indexed = i;
    bus.in_dest    = d;
    bus.in_imm     = imm;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
    end
    if (!acc) check("send_timeout", 0, 1);
    bus.in_valid   = 1'b0;
    bus.in_cond    = 2'($urandom);
    bus.in_src     = 2'($urandom);
    bus.in_indexed = 1'($urandom);
    bus.in_dest    = 3'($urandom);
    bus.in_imm     = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    drive_defaults();
    resetBar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset values, still inside reset.
    @(negedge clk);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, BASE);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_count", bus.instr_count, 0);
    step();
    resetBar = 1'b1;

    // A -> B, single byte.
    send(2'd0, 2'd2, 1'b0, 3'd3, 8'h00);
    @(negedge clk);
    check("t1_wr_en", bus.wr_en, 1);
    check("t1_addr", bus.wr_addr, 8'h00);
    check("t1_data", bus.wr_data, 8'h23);
    step();
    @(negedge clk);
    check("t1_ready_again", bus.in_ready, 1);
    check("t1_count", bus.instr_count, 1);
    step();

    // Immediate load into A.
    do_reset();
    send(2'd0, 2'd0, 1'b0, 3'd2, 8'h5A);
    @(negedge clk);
    check("t2_op_addr", bus.wr_addr, 8'h00);
    check("t2_op_data", bus.wr_data, 8'h02);
    step();
    @(negedge clk);
    check("t2_imm_addr", bus.wr_addr, 8'h01);
    check("t2_imm_data", bus.wr_data, 8'h5A);
    step();
    @(negedge clk);
    check("t2_next_addr", bus.wr_addr, 8'h02);
    step();

    // Unconditional jump with immediate target.
    send(2'd3, 2'd0, 1'b0, 3'd1, 8'h10);
    @(negedge clk);
    check("t3_op_data", bus.wr_data, 8'hC1);
    step();
    @(negedge clk);
    check("t3_imm_data", bus.wr_data, 8'h10);
    step();

    // Stall in OP for three cycles.
    bus.mem_ready = 1'b0;
    send(2'd0, 2'd3, 1'b0, 3'd4, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_hold_en", bus.wr_en, 1);
      check("t4_hold_addr", bus.wr_addr, 8'h04);
      check("t4_hold_data", bus.wr_data, 8'h34);
      step();
    end
    bus.mem_ready = 1'b1;
    step();
    @(negedge clk);
    check("t4_done_en", bus.wr_en, 0);
    check("t4_count", bus.instr_count, 3);
    step();

    // org and request together: org wins, request not accepted.
    bus.org_valid = 1'b1;
    bus.org_addr  = 8'hFF;
    bus.in_valid  = 1'b1;
    bus.in_src    = 2'd2;
    bus.in_dest   = 3'd3;
    @(negedge clk);
    check("t6_ready_low", bus.in_ready, 0);
    step();
    bus.org_valid = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("t6_no_write", bus.wr_en, 0);
    check("t6_org_addr", bus.wr_addr, 8'hFF);
    step();

    // Two-byte instruction straddling the top of memory.
    send(2'd0, 2'd0, 1'b0, 3'd6, 8'hA5);
    @(negedge clk);
    check("t5_op_addr", bus.wr_addr, 8'hFF);
    step();
    @(negedge clk);
    check("t5_imm_addr", bus.wr_addr, 8'h00);
    step();
    @(negedge clk);
    check("t5_wrapped", bus.wrapped, 1);
    step();

    // Mem-to-mem request is rejected.
    send(2'd0, 2'd0, 1'b1, 3'd5, 8'h00);
    @(negedge clk);
    check("t7_err", bus.err, 1);
    check("t7_no_write", bus.wr_en, 0);
    check("t7_count", bus.instr_count, 4);
    step();
    @(negedge clk);
    check("t7_err_pulse", bus.err, 0);
    step();

    // Reset while writing the immediate byte.
    send(2'd0, 2'd0, 1'b0, 3'd2, 8'h33);
    step();
    resetBar = 1'b0;
    @(negedge clk);
    check("t8_in_imm", bus.wr_data, 8'h33);
    step();
    resetBar = 1'b1;
    @(negedge clk);
    check("t8_wr_en", bus.wr_en, 0);
    check("t8_addr", bus.wr_addr, BASE);
    check("t8_count", bus.instr_count, 0);
    step();

    // Randomized traffic; the monitor checks every cycle.
    for (int n = 0; n < 1500; n++) begin
      resetBar       = ($urandom_range(0, 199) != 0);
      bus.org_valid  = ($urandom_range(0, 9) == 0);
      bus.org_addr   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(248, 255))
                                                   : 8'($urandom);
      bus.in_valid   = ($urandom_range(0, 2) != 0);
      bus.in_cond    = 2'($urandom);
      bus.in_src     = 2'($urandom);
      bus.in_indexed = 1'($urandom);
      bus.in_dest    = 3'($urandom);
      bus.in_imm     = 8'($urandom);
      bus.mem_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    drive_defaults();
    resetBar = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check("drain_idle", bus.wr_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
